// File: rtl/sram_bytemask_bank.sv
// Byte-maskable single-clock SRAM bank with a built-in clear engine that zeroes the array.
// Optional macro SRAM_WR_BYPASS_EN selects write-first on same-address read/write collisions.
module sram_bytemask_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_csb,
  input  logic                i_wsb,
  input  logic [DATA_W/8-1:0] i_bytemask,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [ADDR_W-1:0]   i_waddr,
  input  logic [ADDR_W-1:0]   i_raddr,
  input  logic                i_clr,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rvalid,
  output logic                o_busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  if ((DATA_W % 8) != 0 || DATA_W < 8) begin : g_bad_data_w
    $error("DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH < 2 || IDX_W > ADDR_W) begin : g_bad_depth
    $error("DEPTH must be at least 2 and addressable with ADDR_W bits");
  end

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [DATA_W-1:0]  r_rdata;
  logic               r_rvalid;

  logic               w_ready;
  logic               w_access;
  logic               w_wr_en;
  logic               w_wr_in_range;
  logic               w_rd_in_range;
  logic [IDX_W-1:0]   w_widx;
  logic [IDX_W-1:0]   w_ridx;
  logic [DATA_W-1:0]  w_rd_word;
  logic [DATA_W-1:0]  w_rd_data;

  assign w_widx        = i_waddr[IDX_W-1:0];
  assign w_ridx        = i_raddr[IDX_W-1:0];
  assign w_wr_in_range = ({1'b0, i_waddr} < DEPTH_EXT);
  assign w_rd_in_range = ({1'b0, i_raddr} < DEPTH_EXT);

  // An accepted clr squashes any read or write presented in the same cycle.
  assign w_ready  = (r_state == StReady);
  assign w_access = w_ready & ~i_clr & ~i_csb;
  assign w_wr_en  = w_access & ~i_wsb & w_wr_in_range;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      StClear: begin
        if (r_cnt == LAST_IDX) begin
          w_state_nxt = StReady;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      StReady: begin
        if (i_clr) begin
          w_state_nxt = StClear;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StClear;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StClear;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Array has no reset; the clear engine owns initialisation.
  always_ff @(posedge i_clk) begin
    if (r_state == StClear) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < NB; i++) begin
        if (i_bytemask[i]) begin
          r_mem[w_widx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  assign w_rd_word = w_rd_in_range ? r_mem[w_ridx] : '0;

`ifdef SRAM_WR_BYPASS_EN
  always_comb begin
    w_rd_data = w_rd_word;
    if (w_wr_en && (i_waddr == i_raddr)) begin
      for (int i = 0; i < NB; i++) begin
        if (i_bytemask[i]) begin
          w_rd_data[8*i +: 8] = i_wdata[8*i +: 8];
        end
      end
    end
  end
`else
  assign w_rd_data = w_rd_word;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_access;
      if (w_access) begin
        r_rdata <= w_rd_data;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;
  assign o_busy   = (r_state == StClear);

endmodule

// File: doc/sram_bytemask_bank.md
# sram_bytemask_bank

Parametrised byte-maskable single-clock SRAM bank: one write port and one read port, both gated by the chip enable. A built-in clear engine zeroes the whole array after reset or on request. It is the next-generation weight/activation buffer for the 16x16 TPU array, generalising the fixed 256x32 byte-lane buffer to arbitrary width, depth and multi-byte writes. It sits between the host loader and the systolic-array feeders.

## Interface
- DATA_W, 32, word width in bits; must be a multiple of 8, minimum 8
- DEPTH, 256, number of words; minimum 2
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= DEPTH
- NB (localparam), DATA_W/8, number of byte lanes

- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- csb  in  1  chip enable, active low
- wsb  in  1  write enable, active low; effective only with csb=0
- bytemask  in  NB  per-byte write enable; bit i covers wdata[8i+7:8i]
- wdata  in  DATA_W  write data
- waddr  in  ADDR_W  write address
- raddr  in  ADDR_W  read address
- clr  in  1  single-cycle pulse that starts a full-array clear
- rdata  out  DATA_W  registered read data
- rvalid  out  1  high for one cycle when rdata carries new read data
- busy  out  1  clear engine active; all accesses ignored while high

## Operation
- The state machine has two states, CLEAR and READY.
- Reset puts the block in CLEAR with the clear counter at 0. Reset values: rdata=0, rvalid=0, busy=1.
- CLEAR:
  - Writes mem[cnt] <= 0 and increments cnt once per cycle.
  - When cnt=DEPTH-1 is written, the next state is READY and busy falls.
  - The clear takes DEPTH cycles after reset release.
- READY, with clr=1: the next state is CLEAR with cnt=0.
  - clr has priority over a write in the same cycle; that write is dropped.
  - clr in the same cycle as a read: the read is dropped and rvalid stays 0.
  - clr while in CLEAR is ignored; the engine does not restart.
- Write (READY, csb=0, wsb=0):
  - For each i with bytemask[i]=1, byte i of mem[waddr] takes wdata byte i. Unmasked bytes keep their value.
  - bytemask=0 writes nothing. The legacy "default clears word" behaviour is removed.
  - Any combination of mask bits is legal.
- Read (READY, csb=0): rdata <= mem[raddr] and rvalid <= 1 the next cycle. A read does not depend on wsb.
- No read (csb=1, busy=1, or clr accepted): rdata holds its last value and rvalid <= 0.
- Out-of-range address (>= DEPTH):
  - A write is dropped.
  - A read returns 0 with rvalid=1.
- Same-cycle read and write to the same address: read-first. rdata returns the pre-write contents, unless the macro below is defined.
- Reset asserted mid-clear or mid-operation:
  - All outputs return to their reset values immediately, and the clear restarts from 0 on release.
  - Array contents are not guaranteed until the clear completes.

## Timing
- Read latency is 1 cycle: address at edge N, data valid after edge N+1 with rvalid=1 for that cycle.
- Write is visible to a read issued at edge N+1 or later.
- Back-to-back reads on every cycle are supported at full throughput.
- busy deasserts exactly DEPTH cycles after rst_n rises, or DEPTH cycles after the edge at which clr is accepted.
- The first legal access is at the edge where busy is low.

## Configuration
- SRAM_WR_BYPASS_EN defined: a same-cycle read and write to the same in-range address returns the merged data. Masked bytes come from wdata and unmasked bytes from the old word (write-first).
- SRAM_WR_BYPASS_EN undefined: read-first as above. There is no bypass mux.

## Test plan
- Reset and clear, DEPTH=256:
  - busy=1 for 256 cycles after reset release, then 0.
  - A read of address 0x55 then gives rdata=0, rvalid=1.
- Byte masking, DATA_W=32:
  - Write 0xAABBCCDD to addr 3 with mask 4'hF, then 0x11223344 with mask 4'b0101.
  - Read addr 3 -> 0xAA22CC44.
- Zero mask and disabled writes:
  - Write 0xFFFFFFFF to addr 7 with mask 0, then again with csb=1.
  - Read addr 7 -> 0x00000000.
- Same-address collision:
  - Preload addr 9 = 0x12345678.
  - In one cycle, write 0xDEADBEEF with mask 4'hF and read addr 9.
  - rdata=0x12345678 without the macro; 0xDEADBEEF with SRAM_WR_BYPASS_EN.
  - Either way, the next read gives 0xDEADBEEF.
- Mid-run clr:
  - Fill addrs 0..3, pulse clr together with a write to addr 2; busy rises the next cycle.
  - Reads during busy give rvalid=0.
  - After 256 cycles, all four addresses read 0.
- Reset mid-clear and out-of-range (DEPTH=200, ADDR_W=8):
  - Assert rst_n=0 at clear cycle 50; busy stays 1 and the clear restarts, ending 200 cycles after release.
  - A write to addr 250 is dropped; a read of addr 250 -> rdata=0, rvalid=1.
